// File: rtl/isdu_mw_if.sv
`default_nettype none
// ============================================================================
// Module      : isdu_mw_if
// Description : Control bundle between the LC-3 sequencer (isdu_mw) and the
//               rest of the CPU. The sequencer holds the master view: it
//               receives Run/Continue/IR fields/BEN and drives every load
//               enable, bus gate, mux select and memory strobe. The slave
//               view is the datapath side.
// Signals     : Run, Continue, Opcode[3:0], IR_5, IR_11, BEN   (to sequencer)
//               LD_MAR..LD_LED, GatePC/MDR/ALU/MARMUX, PCMUX[1:0], DRMUX,
//               SR1MUX, SR2MUX, ADDR1MUX, ADDR2MUX[1:0], ALUK[1:0],
//               Mem_OE, Mem_WE                                (from sequencer)
// Revision    : 1.0 - initial release
// ============================================================================
interface isdu_mw_if;
  logic       Run;
  logic       Continue;
  logic [3:0] Opcode;
  logic       IR_5;
  logic       IR_11;
  logic       BEN;

  logic       LD_MAR;
  logic       LD_MDR;
  logic       LD_IR;
  logic       LD_BEN;
  logic       LD_CC;
  logic       LD_REG;
  logic       LD_PC;
  logic       LD_LED;
  logic       GatePC;
  logic       GateMDR;
  logic       GateALU;
  logic       GateMARMUX;
  logic [1:0] PCMUX;
  logic       DRMUX;
  logic       SR1MUX;
  logic       SR2MUX;
  logic       ADDR1MUX;
  logic [1:0] ADDR2MUX;
  logic [1:0] ALUK;
  logic       Mem_OE;
  logic       Mem_WE;

  modport master (
    input  Run, Continue, Opcode, IR_5, IR_11, BEN,
    output LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
           GatePC, GateMDR, GateALU, GateMARMUX,
           PCMUX, DRMUX, SR1MUX, SR2MUX, ADDR1MUX, ADDR2MUX, ALUK,
           Mem_OE, Mem_WE
  );

  modport slave (
    output Run, Continue, Opcode, IR_5, IR_11, BEN,
    input  LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
           GatePC, GateMDR, GateALU, GateMARMUX,
           PCMUX, DRMUX, SR1MUX, SR2MUX, ADDR1MUX, ADDR2MUX, ALUK,
           Mem_OE, Mem_WE
  );
endinterface
`default_nettype wire

// File: rtl/isdu_mw.sv
`default_nettype none
// ============================================================================
// Module      : isdu_mw
// Description : LC-3 instruction sequencing and decode unit with a
//               configurable SRAM wait-state count. Executes ADD, AND, NOT,
//               LDR, STR, BR, JMP, JSR/JSRR and (optionally) PAUSE. Every
//               memory access is timed by an internal down-counter so a
//               single state covers the whole access.
// Parameters  : MEM_WAIT - SRAM cycles per read or write (1..15)
// Macro       : ISDU_PAUSE_EN - when defined, opcode 1101 runs the PAUSE
//               sequence (LD_LED + wait for Continue press/release); when
//               undefined, 1101 is a NOP and LD_LED is tied low.
// Ports       : Clk     - system clock, rising edge
//               Reset_n - synchronous active-low reset
//               bus     - isdu_mw_if.master: Run/Continue/Opcode/IR_5/IR_11/
//                         BEN in; all datapath controls and Mem_OE/Mem_WE out
// Revision    : 1.0 - initial release
// ============================================================================
module isdu_mw #(
  parameter int MEM_WAIT = 2
) (
  input  wire logic Clk,
  input  wire logic Reset_n,
  isdu_mw_if.master bus
);

  typedef enum logic [4:0] {
    S_HALTED   = 5'd0,
    S_F_MAR    = 5'd1,
    S_F_MEM    = 5'd2,
    S_F_IR     = 5'd3,
    S_DECODE   = 5'd4,
    S_ADD      = 5'd5,
    S_AND      = 5'd6,
    S_NOT      = 5'd7,
    S_LDR_ADR  = 5'd8,
    S_LDR_MEM  = 5'd9,
    S_LDR_WB   = 5'd10,
    S_STR_ADR  = 5'd11,
    S_STR_DAT  = 5'd12,
    S_STR_MEM  = 5'd13,
    S_BR       = 5'd14,
    S_BR_TAKE  = 5'd15,
    S_JMP      = 5'd16,
    S_JSR_LINK = 5'd17,
    S_JSR_JUMP = 5'd18
`ifdef ISDU_PAUSE_EN
    ,
    S_PAUSE1   = 5'd19,
    S_PAUSE2   = 5'd20
`endif
  } state_t;

  // Counter reload value: an access of MEM_WAIT cycles counts MEM_WAIT-1 .. 0.
  localparam logic [3:0] WAIT_LOAD = 4'(MEM_WAIT - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

`ifdef ISDU_PAUSE_EN
  // Set only on the DECODE->PAUSE1 edge so LD_LED fires on the entry cycle.
  logic       led_q, led_d;
`else
  logic       unused_continue;
  assign unused_continue = bus.Continue;
`endif

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q <= S_HALTED;
      cnt_q   <= 4'd0;
`ifdef ISDU_PAUSE_EN
      led_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
`ifdef ISDU_PAUSE_EN
      led_q   <= led_d;
`endif
    end
  end

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
`ifdef ISDU_PAUSE_EN
    led_d           = 1'b0;
`endif
    bus.LD_MAR      = 1'b0;
    bus.LD_MDR      = 1'b0;
    bus.LD_IR       = 1'b0;
    bus.LD_BEN      = 1'b0;
    bus.LD_CC       = 1'b0;
    bus.LD_REG      = 1'b0;
    bus.LD_PC       = 1'b0;
    bus.LD_LED      = 1'b0;
    bus.GatePC      = 1'b0;
    bus.GateMDR     = 1'b0;
    bus.GateALU     = 1'b0;
    bus.GateMARMUX  = 1'b0;
    bus.PCMUX       = 2'b00;
    bus.DRMUX       = 1'b0;
    bus.SR1MUX      = 1'b0;
    bus.SR2MUX      = 1'b0;
    bus.ADDR1MUX    = 1'b0;
    bus.ADDR2MUX    = 2'b00;
    bus.ALUK        = 2'b00;
    bus.Mem_OE      = 1'b0;
    bus.Mem_WE      = 1'b0;

    case (state_q)
      S_HALTED: begin
        if (bus.Run) state_d = S_F_MAR;
      end
      S_F_MAR: begin
        bus.GatePC = 1'b1;
        bus.LD_MAR = 1'b1;
        bus.LD_PC  = 1'b1;
        cnt_d      = WAIT_LOAD;
        state_d    = S_F_MEM;
      end
      S_F_MEM: begin
        bus.Mem_OE = 1'b1;
        if (cnt_q == 4'd0) begin
          bus.LD_MDR = 1'b1;
          state_d    = S_F_IR;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_F_IR: begin
        bus.GateMDR = 1'b1;
        bus.LD_IR   = 1'b1;
        state_d     = S_DECODE;
      end
      S_DECODE: begin
        bus.LD_BEN = 1'b1;
        case (bus.Opcode)
          4'b0001: state_d = S_ADD;
          4'b0101: state_d = S_AND;
          4'b1001: state_d = S_NOT;
          4'b0110: state_d = S_LDR_ADR;
          4'b0111: state_d = S_STR_ADR;
          4'b0000: state_d = S_BR;
          4'b1100: state_d = S_JMP;
          4'b0100: state_d = S_JSR_LINK;
`ifdef ISDU_PAUSE_EN
          4'b1101: begin
            state_d = S_PAUSE1;
            led_d   = 1'b1;
          end
`endif
          default: state_d = S_F_MAR;
        endcase
      end
      S_ADD, S_AND: begin
        bus.SR1MUX  = 1'b1;
        bus.SR2MUX  = bus.IR_5;
        bus.ALUK    = (state_q == S_AND) ? 2'b01 : 2'b00;
        bus.GateALU = 1'b1;
        bus.LD_REG  = 1'b1;
        bus.LD_CC   = 1'b1;
        state_d     = S_F_MAR;
      end
      S_NOT: begin
        bus.SR1MUX  = 1'b1;
        bus.ALUK    = 2'b10;
        bus.GateALU = 1'b1;
        bus.LD_REG  = 1'b1;
        bus.LD_CC   = 1'b1;
        state_d     = S_F_MAR;
      end
      S_LDR_ADR, S_STR_ADR: begin
        bus.SR1MUX     = 1'b1;
        bus.ADDR1MUX   = 1'b1;
        bus.ADDR2MUX   = 2'b01;
        bus.GateMARMUX = 1'b1;
        bus.LD_MAR     = 1'b1;
        if (state_q == S_LDR_ADR) begin
          cnt_d   = WAIT_LOAD;
          state_d = S_LDR_MEM;
        end else begin
          state_d = S_STR_DAT;
        end
      end
      S_LDR_MEM: begin
        bus.Mem_OE = 1'b1;
        if (cnt_q == 4'd0) begin
          bus.LD_MDR = 1'b1;
          state_d    = S_LDR_WB;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_LDR_WB: begin
        bus.GateMDR = 1'b1;
        bus.LD_REG  = 1'b1;
        bus.LD_CC   = 1'b1;
        state_d     = S_F_MAR;
      end
      S_STR_DAT: begin
        // SR is in IR[11:9]; PASS A drives it onto the bus into MDR.
        bus.SR1MUX  = 1'b0;
        bus.ALUK    = 2'b11;
        bus.GateALU = 1'b1;
        bus.LD_MDR  = 1'b1;
        cnt_d       = WAIT_LOAD;
        state_d     = S_STR_MEM;
      end
      S_STR_MEM: begin
        bus.Mem_WE = 1'b1;
        if (cnt_q == 4'd0) begin
          state_d = S_F_MAR;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_BR: begin
        state_d = bus.BEN ? S_BR_TAKE : S_F_MAR;
      end
      S_BR_TAKE: begin
        bus.ADDR1MUX = 1'b0;
        bus.ADDR2MUX = 2'b10;
        bus.PCMUX    = 2'b10;
        bus.LD_PC    = 1'b1;
        state_d      = S_F_MAR;
      end
      S_JMP: begin
        bus.SR1MUX   = 1'b1;
        bus.ADDR1MUX = 1'b1;
        bus.ADDR2MUX = 2'b00;
        bus.PCMUX    = 2'b10;
        bus.LD_PC    = 1'b1;
        state_d      = S_F_MAR;
      end
      S_JSR_LINK: begin
        bus.GatePC = 1'b1;
        bus.DRMUX  = 1'b1;
        bus.LD_REG = 1'b1;
        state_d    = S_JSR_JUMP;
      end
      S_JSR_JUMP: begin
        // R7 was already overwritten by the link, so JSRR R7 lands on the
        // return address rather than the old R7 contents.
        if (bus.IR_11) begin
          bus.ADDR1MUX = 1'b0;
          bus.ADDR2MUX = 2'b11;
        end else begin
          bus.ADDR1MUX = 1'b1;
          bus.SR1MUX   = 1'b1;
          bus.ADDR2MUX = 2'b00;
        end
        bus.PCMUX = 2'b10;
        bus.LD_PC = 1'b1;
        state_d   = S_F_MAR;
      end
`ifdef ISDU_PAUSE_EN
      S_PAUSE1: begin
        bus.LD_LED = led_q;
        if (bus.Continue) state_d = S_PAUSE2;
      end
      S_PAUSE2: begin
        if (!bus.Continue) state_d = S_F_MAR;
      end
`endif
      default: state_d = S_F_MAR;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_isdu_mw.sv
`default_nettype none
// ============================================================================
// Module      : tb_isdu_mw
// Description : Scoreboard bench for isdu_mw. Two instances (MEM_WAIT=3 and
//               MEM_WAIT=1) share all inputs; each scenario pushes the
//               expected per-cycle control word for the selected instance
//               and compares it with the observed word cycle by cycle.
//               Honours ISDU_PAUSE_EN the same way the design does.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_isdu_mw;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n, run, cont, ir5, ir11, ben, use1;
  logic [3:0] opcode;

  isdu_mw_if if3 ();
  isdu_mw_if if1 ();

  assign if3.Run = run;  assign if3.Continue = cont; assign if3.Opcode = opcode;
  assign if3.IR_5 = ir5; assign if3.IR_11 = ir11;    assign if3.BEN = ben;
  assign if1.Run = run;  assign if1.Continue = cont; assign if1.Opcode = opcode;
  assign if1.IR_5 = ir5; assign if1.IR_11 = ir11;    assign if1.BEN = ben;

  isdu_mw #(.MEM_WAIT(3)) u_dut3 (.Clk(clk), .Reset_n(reset_n), .bus(if3));
  isdu_mw #(.MEM_WAIT(1)) u_dut1 (.Clk(clk), .Reset_n(reset_n), .bus(if1));

  // Control word layout (bit 23 down to 0).
  logic [23:0] obs3, obs1, obs;
  assign obs3 = {if3.LD_MAR, if3.LD_MDR, if3.LD_IR, if3.LD_BEN, if3.LD_CC,
                 if3.LD_REG, if3.LD_PC, if3.LD_LED, if3.GatePC, if3.GateMDR,
                 if3.GateALU, if3.GateMARMUX, if3.PCMUX, if3.DRMUX, if3.SR1MUX,
                 if3.SR2MUX, if3.ADDR1MUX, if3.ADDR2MUX, if3.ALUK,
                 if3.Mem_OE, if3.Mem_WE};
  assign obs1 = {if1.LD_MAR, if1.LD_MDR, if1.LD_IR, if1.LD_BEN, if1.LD_CC,
                 if1.LD_REG, if1.LD_PC, if1.LD_LED, if1.GatePC, if1.GateMDR,
                 if1.GateALU, if1.GateMARMUX, if1.PCMUX, if1.DRMUX, if1.SR1MUX,
                 if1.SR2MUX, if1.ADDR1MUX, if1.ADDR2MUX, if1.ALUK,
                 if1.Mem_OE, if1.Mem_WE};
  assign obs = use1 ? obs1 : obs3;

  localparam logic [23:0] B_LD_MAR  = 24'h1 << 23;
  localparam logic [23:0] B_LD_MDR  = 24'h1 << 22;
  localparam logic [23:0] B_LD_IR   = 24'h1 << 21;
  localparam logic [23:0] B_LD_BEN  = 24'h1 << 20;
  localparam logic [23:0] B_LD_CC   = 24'h1 << 19;
  localparam logic [23:0] B_LD_REG  = 24'h1 << 18;
  localparam logic [23:0] B_LD_PC   = 24'h1 << 17;
  localparam logic [23:0] B_LD_LED  = 24'h1 << 16;
  localparam logic [23:0] B_G_PC    = 24'h1 << 15;
  localparam logic [23:0] B_G_MDR   = 24'h1 << 14;
  localparam logic [23:0] B_G_ALU   = 24'h1 << 13;
  localparam logic [23:0] B_G_MARM  = 24'h1 << 12;
  localparam logic [23:0] B_PC_AA   = 24'h2 << 10;
  localparam logic [23:0] B_DRMUX   = 24'h1 << 9;
  localparam logic [23:0] B_SR1     = 24'h1 << 8;
  localparam logic [23:0] B_SR2     = 24'h1 << 7;
  localparam logic [23:0] B_A1      = 24'h1 << 6;
  localparam logic [23:0] B_A2_6    = 24'h1 << 4;
  localparam logic [23:0] B_A2_9    = 24'h2 << 4;
  localparam logic [23:0] B_A2_11   = 24'h3 << 4;
  localparam logic [23:0] B_K_AND   = 24'h1 << 2;
  localparam logic [23:0] B_K_NOT   = 24'h2 << 2;
  localparam logic [23:0] B_K_PASS  = 24'h3 << 2;
  localparam logic [23:0] B_OE      = 24'h1 << 1;
  localparam logic [23:0] B_WE      = 24'h1;

  localparam logic [23:0] W_FMAR = B_G_PC | B_LD_MAR | B_LD_PC;
  localparam logic [23:0] W_ALU  = B_G_ALU | B_LD_REG | B_LD_CC;
  localparam logic [23:0] W_ADR  = B_SR1 | B_A1 | B_A2_6 | B_G_MARM | B_LD_MAR;

  logic [23:0] exp_q[$];
  int n_total = 0;
  int n_pass  = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset both instances, then pulse Run so both sit in F_MAR at return.
  task automatic start();
    reset_n = 1'b0;
    step(); step();
    reset_n = 1'b1;
    run = 1'b1;
    step();
    run = 1'b0;
  endtask

  task automatic push_mem(input int mw, input bit rd);
    for (int i = mw - 1; i >= 0; i--)
      exp_q.push_back(rd ? (B_OE | ((i == 0) ? B_LD_MDR : 24'h0)) : B_WE);
  endtask

  // Expected cycle-by-cycle control words for one instruction, fetch first.
  task automatic push_instr(input int mw, input logic [3:0] op,
                            input logic i5, input logic i11, input logic bn);
    exp_q.push_back(W_FMAR);
    push_mem(mw, 1'b1);
    exp_q.push_back(B_G_MDR | B_LD_IR);
    exp_q.push_back(B_LD_BEN);
    case (op)
      4'b0001: exp_q.push_back(W_ALU | B_SR1 | (i5 ? B_SR2 : 24'h0));
      4'b0101: exp_q.push_back(W_ALU | B_SR1 | (i5 ? B_SR2 : 24'h0) | B_K_AND);
      4'b1001: exp_q.push_back(W_ALU | B_SR1 | B_K_NOT);
      4'b0110: begin
        exp_q.push_back(W_ADR);
        push_mem(mw, 1'b1);
        exp_q.push_back(B_G_MDR | B_LD_REG | B_LD_CC);
      end
      4'b0111: begin
        exp_q.push_back(W_ADR);
        exp_q.push_back(B_K_PASS | B_G_ALU | B_LD_MDR);
        push_mem(mw, 1'b0);
      end
      4'b0000: begin
        exp_q.push_back(24'h0);
        if (bn) exp_q.push_back(B_A2_9 | B_PC_AA | B_LD_PC);
      end
      4'b1100: exp_q.push_back(B_SR1 | B_A1 | B_PC_AA | B_LD_PC);
      4'b0100: begin
        exp_q.push_back(B_G_PC | B_DRMUX | B_LD_REG);
        exp_q.push_back(i11 ? (B_A2_11 | B_PC_AA | B_LD_PC)
                            : (B_A1 | B_SR1 | B_PC_AA | B_LD_PC));
      end
`ifdef ISDU_PAUSE_EN
      4'b1101: exp_q.push_back(B_LD_LED);
`endif
      default: ;
    endcase
  endtask

  task automatic test_reset();
    reset_n = 1'b0; run = 1'b0; cont = 1'b0; opcode = 4'b0000;
    ir5 = 1'b0; ir11 = 1'b0; ben = 1'b0; use1 = 1'b0;
    step(); step();
    n_total++;
    if (obs3 !== 24'h0) $display("FAIL reset_mw3: got %h expected %h", obs3, 24'h0);
    else n_pass++;
    n_total++;
    if (obs1 !== 24'h0) $display("FAIL reset_mw1: got %h expected %h", obs1, 24'h0);
    else n_pass++;
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_total++;
      if ((obs3 | obs1) !== 24'h0)
        $display("FAIL halted_idle cyc%0d: got %h/%h expected 000000", i, obs3, obs1);
      else n_pass++;
    end
  endtask

  task automatic test_alu();
    logic [23:0] e;
    int cyc;
    use1 = 1'b0; opcode = 4'b0001; ir5 = 1'b1;
    start();
    for (int k = 0; k < 3; k++) begin
      case (k)
        0: begin opcode = 4'b0001; ir5 = 1'b1; end
        1: begin opcode = 4'b0101; ir5 = 1'b0; end
        default: begin opcode = 4'b1001; ir5 = 1'b1; end
      endcase
      push_instr(3, opcode, ir5, 1'b0, 1'b0);
      if (k == 2) exp_q.push_back(W_FMAR);
      cyc = 0;
      while (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_total++;
        if (obs !== e) $display("FAIL alu op%0d cyc%0d: got %h expected %h", k, cyc, obs, e);
        else n_pass++;
        cyc++;
        step();
      end
    end
  endtask

  task automatic test_ldr_str(input int mw);
    logic [23:0] e;
    int cyc, we_cnt;
    use1 = (mw == 1); opcode = 4'b0110;
    start();
    for (int k = 0; k < 2; k++) begin
      opcode = (k == 0) ? 4'b0110 : 4'b0111;
      push_instr(mw, opcode, 1'b0, 1'b0, 1'b0);
      if (k == 1) exp_q.push_back(W_FMAR);
      cyc = 0; we_cnt = 0;
      while (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_total++;
        if (obs !== e) $display("FAIL ldst mw%0d op%0d cyc%0d: got %h expected %h", mw, k, cyc, obs, e);
        else n_pass++;
        if (obs[0] === 1'b1) we_cnt++;
        cyc++;
        step();
      end
      n_total++;
      if (we_cnt !== ((k == 0) ? 0 : mw))
        $display("FAIL we_count mw%0d op%0d: got %0d expected %0d", mw, k, we_cnt, (k == 0) ? 0 : mw);
      else n_pass++;
    end
  endtask

  task automatic test_branch_jump();
    logic [23:0] e;
    int cyc;
    use1 = 1'b0; opcode = 4'b0000; ben = 1'b0;
    start();
    for (int k = 0; k < 5; k++) begin
      case (k)
        0: begin opcode = 4'b0000; ben = 1'b0; end
        1: begin opcode = 4'b0000; ben = 1'b1; end
        2: begin opcode = 4'b0100; ir11 = 1'b1; ben = 1'b0; end
        3: begin opcode = 4'b0100; ir11 = 1'b0; end
        default: opcode = 4'b1100;
      endcase
      push_instr(3, opcode, 1'b0, ir11, ben);
      if (k == 4) exp_q.push_back(W_FMAR);
      cyc = 0;
      while (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_total++;
        if (obs !== e) $display("FAIL brjmp case%0d cyc%0d: got %h expected %h", k, cyc, obs, e);
        else n_pass++;
        cyc++;
        step();
      end
    end
  endtask

  task automatic test_nop();
    logic [23:0] e;
    int cyc;
    use1 = 1'b1; opcode = 4'b1111;
    start();
    for (int k = 0; k < 3; k++) begin
      case (k)
        0: opcode = 4'b1111;
        1: opcode = 4'b0011;
`ifdef ISDU_PAUSE_EN
        default: opcode = 4'b1000;
`else
        default: opcode = 4'b1101;
`endif
      endcase
      push_instr(1, opcode, 1'b0, 1'b0, 1'b0);
      if (k == 2) exp_q.push_back(W_FMAR);
      cyc = 0;
      while (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_total++;
        if (obs !== e) $display("FAIL nop op%h cyc%0d: got %h expected %h", opcode, cyc, obs, e);
        else n_pass++;
        cyc++;
        step();
      end
    end
  endtask

  task automatic test_reset_mid_access();
    logic [23:0] e;
    int cyc;
    use1 = 1'b0; opcode = 4'b0001; ir5 = 1'b0;
    start();
    step(); step();
    reset_n = 1'b0;
    step();
    n_total++;
    if (obs !== 24'h0) $display("FAIL reset_mid_mem: got %h expected %h", obs, 24'h0);
    else n_pass++;
    reset_n = 1'b1;
    run = 1'b1;
    step();
    run = 1'b0;
    push_instr(3, opcode, ir5, 1'b0, 1'b0);
    exp_q.push_back(W_FMAR);
    cyc = 0;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_total++;
      if (obs !== e) $display("FAIL refetch cyc%0d: got %h expected %h", cyc, obs, e);
      else n_pass++;
      cyc++;
      step();
    end
  endtask

`ifdef ISDU_PAUSE_EN
  task automatic test_pause();
    logic [23:0] e;
    int cyc;
    use1 = 1'b0; opcode = 4'b1101; cont = 1'b0;
    start();
    for (int ph = 0; ph < 5; ph++) begin
      case (ph)
        0: begin
          push_instr(3, 4'b1101, 1'b0, 1'b0, 1'b0);
          repeat (3) exp_q.push_back(24'h0);
        end
        1: begin
          cont = 1'b1;
          repeat (3) exp_q.push_back(24'h0);
        end
        2: begin
          cont = 1'b0;
          exp_q.push_back(24'h0);
          push_instr(3, 4'b1101, 1'b0, 1'b0, 1'b0);
          exp_q.push_back(24'h0);
        end
        3: begin
          cont = 1'b1;
          repeat (2) exp_q.push_back(24'h0);
        end
        default: begin
          reset_n = 1'b0;
          step();
          reset_n = 1'b1;
          cont = 1'b0;
          repeat (3) exp_q.push_back(24'h0);
        end
      endcase
      cyc = 0;
      while (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_total++;
        if (obs !== e) $display("FAIL pause ph%0d cyc%0d: got %h expected %h", ph, cyc, obs, e);
        else n_pass++;
        cyc++;
        step();
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_alu();
    test_ldr_str(1);
    test_ldr_str(3);
    test_branch_jump();
    test_nop();
    test_reset_mid_access();
`ifdef ISDU_PAUSE_EN
    test_pause();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
